// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational ROM, buffers
// {pc, instruction} pairs in a small in-order FIFO and hands them to decode.
// Handshake: decode takes the head on any cycle where dec_valid & dec_ready
// are both high; dec_valid never depends on dec_ready, and the head holds
// steady while dec_valid is high and dec_ready is low.
// A branch redirect flushes the buffer. Fetching the HALT word parks the
// stage until the next redirect.
module instr_fetch #(
    parameter int              PC_W       = 30,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [15:0]     HALT_INSTR = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] rom_pc,
    input  logic [15:0]     rom_instruction,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    output logic            dec_valid,
    output logic [15:0]     dec_instr,
    output logic [PC_W-1:0] dec_pc,
    input  logic            dec_ready,
    output logic            halted
);

    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0] mem_pc_q    [FIFO_DEPTH];
    logic [PC_W-1:0] mem_pc_d    [FIFO_DEPTH];
    logic [15:0]     mem_instr_q [FIFO_DEPTH];
    logic [15:0]     mem_instr_d [FIFO_DEPTH];

    logic            pop;
    logic            fetch;
    logic [IW-1:0]   wr_idx;

    // Entry 0 is always the head; the buffer shifts down on a pop so the
    // decode outputs come straight from flops and keep their value when empty.
    assign rom_pc    = pc_q;
    assign dec_valid = (cnt_q != '0);
    assign dec_pc    = mem_pc_q[0];
    assign dec_instr = mem_instr_q[0];
    assign halted    = (state_q == ST_HALT);

    assign pop    = dec_valid & dec_ready;
    // A pop frees a slot in the same cycle, so a full buffer keeps streaming.
    assign fetch  = (state_q == ST_RUN) & ~br_valid &
                    ((cnt_q < CW'(FIFO_DEPTH)) | pop);
    // Slot the new entry lands in, after any shift caused by the pop.
    assign wr_idx = cnt_q[IW-1:0] - IW'(pop);

    // Next-state logic: redirect beats push, refill and the halt transition.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;

        // Shift only slots that hold live entries so the head keeps its
        // last value when the buffer drains.
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            if (pop && ((i + 1) < int'(cnt_q))) begin
                mem_pc_d[i]    = mem_pc_q[i+1];
                mem_instr_d[i] = mem_instr_q[i+1];
            end
        end

        if (br_valid) begin
            pc_d    = br_target & ~PC_W'(1);
            cnt_d   = '0;
            state_d = ST_RUN;
        end else begin
            if (fetch) begin
                mem_pc_d[wr_idx]    = pc_q;
                mem_instr_d[wr_idx] = rom_instruction;
                pc_d                = pc_q + PC_W'(2);
                if (rom_instruction == HALT_INSTR) begin
                    state_d = ST_HALT;
                end
            end
            cnt_d = cnt_q + CW'(fetch) - CW'(pop);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural ROM, two instances (reset
// PC 0 and reset PC at the top of the address space) and hand-computed
// expectations checked on the falling clock edge.
module tb_instr_fetch;

    localparam int PC_W = 30;

    logic            clk;
    logic            rst;
    logic            br_valid;
    logic [PC_W-1:0] br_target;
    logic            dec_ready;

    logic [PC_W-1:0] rom_pc_a, rom_pc_b;
    logic [15:0]     rom_instr_a, rom_instr_b;
    logic            dec_valid_a, dec_valid_b;
    logic [15:0]     dec_instr_a, dec_instr_b;
    logic [PC_W-1:0] dec_pc_a, dec_pc_b;
    logic            halted_a, halted_b;

    int checks;
    int errors;

    // Program image used by the tests; unlisted addresses get a filler word.
    function automatic logic [15:0] rom_word(input logic [PC_W-1:0] pc);
        case (pc)
            30'h0:   rom_word = 16'h5CCD;
            30'h2:   rom_word = 16'h1234;
            30'h4:   rom_word = 16'h9200;
            30'h6:   rom_word = 16'h9A00;
            30'h8:   rom_word = 16'h8DAE;
            30'hA:   rom_word = 16'hB000;
            30'hC:   rom_word = 16'hB80E;
            30'hE:   rom_word = 16'hFFFF;
            default: rom_word = {8'h01, pc[7:0]};
        endcase
    endfunction

    assign rom_instr_a = rom_word(rom_pc_a);
    assign rom_instr_b = rom_word(rom_pc_b);

    instr_fetch #(.PC_W(PC_W), .RESET_PC(30'h0)) dut_a (
        .clk(clk), .rst(rst), .rom_pc(rom_pc_a), .rom_instruction(rom_instr_a),
        .br_valid(br_valid), .br_target(br_target), .dec_valid(dec_valid_a),
        .dec_instr(dec_instr_a), .dec_pc(dec_pc_a), .dec_ready(dec_ready),
        .halted(halted_a)
    );

    instr_fetch #(.PC_W(PC_W), .RESET_PC(30'h3FFFFFFE)) dut_b (
        .clk(clk), .rst(rst), .rom_pc(rom_pc_b), .rom_instruction(rom_instr_b),
        .br_valid(br_valid), .br_target(br_target), .dec_valid(dec_valid_b),
        .dec_instr(dec_instr_b), .dec_pc(dec_pc_b), .dec_ready(dec_ready),
        .halted(halted_b)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Reset on a falling edge, release on the next falling edge.
    task automatic apply_reset(input logic ready);
        rst       = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        dec_ready = ready;
        next_cycle();
        rst = 1'b0;
    endtask

    logic [15:0] exp_words [7];
    initial begin
        exp_words[0] = 16'h5CCD; exp_words[1] = 16'h1234; exp_words[2] = 16'h9200;
        exp_words[3] = 16'h9A00; exp_words[4] = 16'h8DAE; exp_words[5] = 16'hB000;
        exp_words[6] = 16'hB80E;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        dec_ready = 1'b1;

        // Reset state.
        next_cycle();
        check("rst_valid", 32'(dec_valid_a), 32'h0);
        check("rst_pc", 32'(dec_pc_a), 32'h0);
        check("rst_instr", 32'(dec_instr_a), 32'h0);
        check("rst_halted", 32'(halted_a), 32'h0);
        check("rst_rom_pc", 32'(rom_pc_a), 32'h0);
        check("rst_rom_pc_b", 32'(rom_pc_b), 32'h3FFFFFFE);
        rst = 1'b0;

        // Streaming with decode always ready; also the wrap-around instance.
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            check($sformatf("s1_valid%0d", i), 32'(dec_valid_a), 32'h1);
            check($sformatf("s1_pc%0d", i), 32'(dec_pc_a), 32'(2 * i));
            check($sformatf("s1_instr%0d", i), 32'(dec_instr_a), 32'(exp_words[i]));
            if (i == 0) check("wrap_pc0", 32'(dec_pc_b), 32'h3FFFFFFE);
            if (i == 1) check("wrap_pc1", 32'(dec_pc_b), 32'h0);
        end

        // HALT word is delivered, then fetching stops.
        next_cycle();
        check("halt_pc", 32'(dec_pc_a), 32'hE);
        check("halt_instr", 32'(dec_instr_a), 32'hFFFF);
        check("halt_flag", 32'(halted_a), 32'h1);
        check("halt_rom_pc", 32'(rom_pc_a), 32'h10);
        for (int i = 0; i < 3; i++) next_cycle();
        check("halt_empty", 32'(dec_valid_a), 32'h0);
        check("halt_rom_hold", 32'(rom_pc_a), 32'h10);
        check("halt_hold", 32'(halted_a), 32'h1);
        check("halt_head_hold", 32'(dec_pc_a), 32'hE);
        // Redirect leaves HALT and restarts at 0.
        br_valid  = 1'b1;
        br_target = 30'h0;
        next_cycle();
        br_valid = 1'b0;
        check("unhalt_flag", 32'(halted_a), 32'h0);
        check("unhalt_bubble", 32'(dec_valid_a), 32'h0);
        next_cycle();
        check("unhalt_valid", 32'(dec_valid_a), 32'h1);
        check("unhalt_pc", 32'(dec_pc_a), 32'h0);

        // Asynchronous reset between edges takes effect before the next edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(dec_valid_a), 32'h0);
        check("arst_halted", 32'(halted_a), 32'h0);
        check("arst_rom_pc", 32'(rom_pc_a), 32'h0);
        check("arst_rom_pc_b", 32'(rom_pc_b), 32'h3FFFFFFE);

        // Back-pressure: buffer fills with 0,2 and everything holds.
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) next_cycle();
        check("bp_valid", 32'(dec_valid_a), 32'h1);
        check("bp_pc", 32'(dec_pc_a), 32'h0);
        check("bp_rom_pc", 32'(rom_pc_a), 32'h4);
        dec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            check($sformatf("bp_drain_valid%0d", i), 32'(dec_valid_a), 32'h1);
            check($sformatf("bp_drain_pc%0d", i), 32'(dec_pc_a), 32'(2 * i));
        end

        // Redirect with a full buffer while the head transfers.
        apply_reset(1'b0);
        next_cycle();
        next_cycle();
        check("br_full_rom_pc", 32'(rom_pc_a), 32'h4);
        dec_ready = 1'b1;
        br_valid  = 1'b1;
        br_target = 30'hA;
        check("br_xfer_valid", 32'(dec_valid_a), 32'h1);
        check("br_xfer_pc", 32'(dec_pc_a), 32'h0);
        next_cycle();
        br_valid = 1'b0;
        check("br_bubble", 32'(dec_valid_a), 32'h0);
        check("br_rom_pc", 32'(rom_pc_a), 32'hA);
        next_cycle();
        check("br_tgt_valid", 32'(dec_valid_a), 32'h1);
        check("br_tgt_pc", 32'(dec_pc_a), 32'hA);
        check("br_tgt_instr", 32'(dec_instr_a), 32'hB000);

        // Odd redirect target is forced even.
        br_valid  = 1'b1;
        br_target = 30'hD;
        next_cycle();
        br_valid = 1'b0;
        check("odd_bubble", 32'(dec_valid_a), 32'h0);
        check("odd_rom_pc", 32'(rom_pc_a), 32'hC);
        next_cycle();
        check("odd_pc", 32'(dec_pc_a), 32'hC);
        check("odd_instr", 32'(dec_instr_a), 32'hB80E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
